// File: rtl/mmss_timer_if.sv
// Control and display signals of the mm:ss timer. The master drives the
// controls and the preset; the slave (the timer) drives the count and status.
interface mmss_timer_if;
  logic       load;
  logic [6:0] load_min;
  logic [5:0] load_sec;
  logic       start;
  logic       pause;
  logic       clear;
  logic       up;
  logic [6:0] min;
  logic [5:0] sec;
  logic       running;
  logic       done;
  logic       done_pulse;

  modport master (
    output load, load_min, load_sec, start, pause, clear, up,
    input  min, sec, running, done, done_pulse
  );

  modport slave (
    input  load, load_min, load_sec, start, pause, clear, up,
    output min, sec, running, done, done_pulse
  );
endinterface

// File: rtl/mmss_timer.sv
// Minutes:seconds countdown timer / stopwatch with a prescaled one-second tick,
// pause/resume, preset load with clamping, and a saturating terminal DONE state.
module mmss_timer #(
  parameter int unsigned TICK_DIV = 100000000,
  parameter int unsigned SEC_MAX  = 59,
  parameter int unsigned MIN_MAX  = 99
) (
  input logic         clk,
  input logic         rst_n,
  mmss_timer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic [26:0] PRESC_LAST = 27'(TICK_DIV - 1);
  localparam logic [5:0]  SEC_TOP    = 6'(SEC_MAX);
  localparam logic [6:0]  MIN_TOP    = 7'(MIN_MAX);

  state_e      state_q, state_d;
  logic [6:0]  min_q, min_d;
  logic [5:0]  sec_q, sec_d;
  logic [26:0] presc_q, presc_d;
  logic        dir_q, dir_d;
  logic        running_q, running_d;
  logic        done_q, done_d;
  logic        entry_q, entry_d;
  logic        done_pulse_q, done_pulse_d;
  logic        tick;

  assign tick = (state_q == RUN) && (presc_q == PRESC_LAST);

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    min_d   = min_q;
    sec_d   = sec_q;
    presc_d = presc_q;
    dir_d   = dir_q;

    if (bus.clear) begin
      state_d = IDLE;
      min_d   = '0;
      sec_d   = '0;
      presc_d = '0;
      dir_d   = 1'b0;
    end else if (bus.load && (state_q == IDLE || state_q == DONE)) begin
      state_d = IDLE;
      min_d   = (bus.load_min > MIN_TOP) ? MIN_TOP : bus.load_min;
      sec_d   = (bus.load_sec > SEC_TOP) ? SEC_TOP : bus.load_sec;
      presc_d = '0;
    end else if (bus.pause && state_q == RUN) begin
      state_d = PAUSED;
    end else if (bus.start && state_q == IDLE) begin
      // A countdown from 00:00 has nothing to count and would end at once.
      if (bus.up || min_q != '0 || sec_q != '0) begin
        state_d = RUN;
        dir_d   = bus.up;
        presc_d = '0;
      end
    end else if (bus.start && state_q == PAUSED) begin
      state_d = RUN;
    end else if (state_q == RUN) begin
      if (!tick) begin
        presc_d = presc_q + 27'd1;
      end else begin
        presc_d = '0;
        if (!dir_q) begin
          if (sec_q != '0) begin
            sec_d = sec_q - 6'd1;
            if (sec_q == 6'd1 && min_q == '0) state_d = DONE;
          end else if (min_q != '0) begin
            sec_d = SEC_TOP;
            min_d = min_q - 7'd1;
          end else begin
            state_d = DONE;
          end
        end else begin
          if (sec_q < SEC_TOP) begin
            sec_d = sec_q + 6'd1;
            if (sec_q == SEC_TOP - 6'd1 && min_q == MIN_TOP) state_d = DONE;
          end else if (min_q < MIN_TOP) begin
            sec_d = '0;
            min_d = min_q + 7'd1;
          end else begin
            state_d = DONE;
          end
        end
      end
    end

    running_d    = (state_d == RUN);
    done_d       = (state_d == DONE);
    entry_d      = (state_q != DONE) && (state_d == DONE);
    // The strobe trails the DONE level by one cycle.
    done_pulse_d = entry_q;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples the
  // pre-edge values computed above, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      min_q        <= '0;
      sec_q        <= '0;
      presc_q      <= '0;
      dir_q        <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      entry_q      <= 1'b0;
      done_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      min_q        <= min_d;
      sec_q        <= sec_d;
      presc_q      <= presc_d;
      dir_q        <= dir_d;
      running_q    <= running_d;
      done_q       <= done_d;
      entry_q      <= entry_d;
      done_pulse_q <= done_pulse_d;
    end
  end

  assign bus.min        = min_q;
  assign bus.sec        = sec_q;
  assign bus.running    = running_q;
  assign bus.done       = done_q;
  assign bus.done_pulse = done_pulse_q;

endmodule

// File: tb/tb_mmss_timer.sv
// Directed bench for mmss_timer with a 4-cycle tick; expected values are
// worked out by hand from the timer's cycle-level behaviour.
module tb_mmss_timer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  mmss_timer_if bus ();

  mmss_timer #(
    .TICK_DIV(4),
    .SEC_MAX (59),
    .MIN_MAX (99)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_time(input string tag, input int exp_min, input int exp_sec);
    check({tag, ".min"}, 32'(bus.min), 32'(exp_min));
    check({tag, ".sec"}, 32'(bus.sec), 32'(exp_sec));
  endtask

  task automatic check_flags(input string tag, input logic run, input logic dn, input logic pls);
    check({tag, ".running"},    32'(bus.running),    32'(run));
    check({tag, ".done"},       32'(bus.done),       32'(dn));
    check({tag, ".done_pulse"}, 32'(bus.done_pulse), 32'(pls));
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.load = 0; bus.load_min = '0; bus.load_sec = '0;
    bus.start = 0; bus.pause = 0; bus.clear = 0; bus.up = 0;

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    check_time("reset", 0, 0);
    check_flags("reset", 0, 0, 0);
    #9 rst_n = 1'b1;
    step(1);

    // Out-of-range preset clamps to 99:59
    bus.load = 1; bus.load_min = 7'd120; bus.load_sec = 6'd63;
    step(1);
    bus.load = 0;
    check_time("clamp", 99, 59);
    check_flags("clamp", 0, 0, 0);

    // Stopwatch already at maximum: first tick ends in DONE, value saturated
    bus.up = 1; bus.start = 1;
    step(1);
    bus.start = 0;
    check_flags("sw_max_start", 1, 0, 0);
    step(3);
    check_time("sw_max_pre", 99, 59);
    check_flags("sw_max_pre", 1, 0, 0);
    step(1);
    check_time("sw_max_done", 99, 59);
    check_flags("sw_max_done", 0, 1, 0);
    step(1);
    check_flags("sw_max_pulse", 0, 1, 1);
    step(1);
    check_flags("sw_max_after", 0, 1, 0);
    bus.start = 1;
    step(1);
    bus.start = 0;
    check_flags("start_in_done", 0, 1, 0);

    // LOAD from DONE, then 00:02 countdown
    bus.load = 1; bus.load_min = 7'd0; bus.load_sec = 6'd2;
    step(1);
    bus.load = 0;
    check_time("load_in_done", 0, 2);
    check_flags("load_in_done", 0, 0, 0);
    bus.up = 0; bus.start = 1;
    step(1);
    bus.start = 0;
    step(3);
    check_time("cd_e3", 0, 2);
    step(1);
    check_time("cd_e4", 0, 1);
    check_flags("cd_e4", 1, 0, 0);
    step(3);
    check_time("cd_e7", 0, 1);
    step(1);
    check_time("cd_e8", 0, 0);
    check_flags("cd_e8", 0, 1, 0);
    step(1);
    check_flags("cd_e9", 0, 1, 1);
    step(1);
    check_flags("cd_e10", 0, 1, 0);

    // 01:00 countdown borrows into seconds
    bus.load = 1; bus.load_min = 7'd1; bus.load_sec = 6'd0;
    step(1);
    bus.load = 0;
    bus.start = 1;
    step(1);
    bus.start = 0;
    step(4);
    check_time("borrow", 0, 59);
    check_flags("borrow", 1, 0, 0);

    // CLEAR wins over LOAD while running
    bus.clear = 1; bus.load = 1; bus.load_min = 7'd5; bus.load_sec = 6'd5;
    step(1);
    bus.clear = 0; bus.load = 0;
    check_time("clear_load", 0, 0);
    check_flags("clear_load", 0, 0, 0);

    // Countdown START from 00:00 stays idle
    bus.up = 0; bus.start = 1;
    step(1);
    bus.start = 0;
    check_flags("start_zero", 0, 0, 0);
    step(4);
    check_time("start_zero", 0, 0);

    // Stopwatch carry 00:59 -> 01:00
    bus.load = 1; bus.load_min = 7'd0; bus.load_sec = 6'd59;
    step(1);
    bus.load = 0;
    bus.up = 1; bus.start = 1;
    step(1);
    bus.start = 0; bus.up = 0;
    step(4);
    check_time("carry", 1, 0);
    check_flags("carry", 1, 0, 0);
    bus.clear = 1;
    step(1);
    bus.clear = 0;

    // Pause with prescaler at 2, resume: next tick two cycles later
    bus.load = 1; bus.load_min = 7'd0; bus.load_sec = 6'd5;
    step(1);
    bus.load = 0;
    bus.start = 1;
    step(1);
    bus.start = 0;
    step(2);
    bus.pause = 1;
    step(1);
    bus.pause = 0;
    check_flags("paused", 0, 0, 0);
    step(9);
    check_time("paused_hold", 0, 5);
    bus.start = 1;
    step(1);
    bus.start = 0;
    check_flags("resumed", 1, 0, 0);
    step(1);
    check_time("resume_r1", 0, 5);
    step(1);
    check_time("resume_r2", 0, 4);

    // Pause on the tick cycle defers the tick to the first cycle after resume
    step(3);
    bus.pause = 1;
    step(1);
    bus.pause = 0;
    check_time("pause_tick", 0, 4);
    step(2);
    check_time("pause_tick_hold", 0, 4);
    bus.start = 1;
    step(1);
    bus.start = 0;
    check_time("resume_tick_r0", 0, 4);
    step(1);
    check_time("resume_tick_r1", 0, 3);

    // Asynchronous reset mid-run, no clock edge needed
    #2 rst_n = 1'b0;
    #1;
    check_time("async_rst", 0, 0);
    check_flags("async_rst", 0, 0, 0);
    #2 rst_n = 1'b1;
    step(1);
    check_time("post_rst", 0, 0);
    check_flags("post_rst", 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
